pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 50 +++++
 rtl/pipe_ctrl_fwd_unit.sv | 32 +++
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared processor-pipeline definitions.
//   - FSM state encodings for the pipeline controller
//   - forwarding select codes (FWD_RF / FWD_MEM / FWD_WB)
//   - packed control-bundle type and its canonical values
//   - fwd_select(): operand-forwarding priority function
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic pc_en;
        logic if2id_en;
        logic id2ex_en;
        logic ex2mem_en;
        logic mem2wb_en;
        logic if2id_flush;
        logic id2ex_bubble;
        logic mem2wb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF      = ctrl_t'(8'b00000_000);
    localparam ctrl_t CTRL_RUN      = ctrl_t'(8'b11111_000);
    localparam ctrl_t CTRL_BRANCH   = ctrl_t'(8'b11111_110);
    localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(8'b00111_010);
    // Freeze keeps mem2wb_en high so the NOP actually gets loaded into MEM2WB.
    localparam ctrl_t CTRL_FREEZE   = ctrl_t'(8'b00001_001);

    // MEM result wins over WB result; register 0 is hard-wired and never forwards.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic       mem_wb_en,
        input logic [4:0] mem_dest,
        input logic       wb_wb_en,
        input logic [4:0] wb_dest
    );
        if (mem_wb_en && (mem_dest != 5'd0) && (mem_dest == src))
            return FWD_MEM;
        else if (wb_wb_en && (wb_dest != 5'd0) && (wb_dest == src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// fwd_unit: combinational EX operand-forwarding selects.
//   ex_src1/ex_src2       : EX-stage source registers
//   mem_wb_en/mem_dest    : MEM-stage register write
//   wb_wb_en/wb_dest      : WB-stage register write
//   fwd_a/fwd_b           : operand selects (FWD_RF / FWD_MEM / FWD_WB)
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_src1,
    input  logic [4:0] ex_src2,
    input  logic       mem_wb_en,
    input  logic [4:0] mem_dest,
    input  logic       wb_wb_en,
    input  logic [4:0] wb_dest,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic [4:0] src [2];
    logic [1:0] sel [2];

    assign src[0] = ex_src1;
    assign src[1] = ex_src2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
        assign sel[gi] = fwd_select(src[gi], mem_wb_en, mem_dest, wb_wb_en, wb_dest);
    end

    assign fwd_a = sel[0];
    assign fwd_b = sel[1];

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard / stall / forwarding controller for a 5-stage pipeline.
//   clk, rst (sync, active-low)
//   id_*, ex_*           : operand/destination info for hazard detection
//   branch_taken         : EX resolved a taken branch
//   mem_*/wb_*           : write-back info for forwarding
//   mem_req/mem_ready    : data-memory handshake
//   *_en, *_flush, *_bubble : stage-register controls (combinational)
//   fwd_a/fwd_b          : EX operand selects (combinational)
//   stall_cnt            : saturating count of cycles with pc_en=0
//   mem_err              : sticky memory-timeout flag
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_src1,
    input  logic [4:0]  id_src2,
    input  logic        id_two_src,
    input  logic [4:0]  ex_src1,
    input  logic [4:0]  ex_src2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dest,
    input  logic        branch_taken,
    input  logic        mem_wb_en,
    input  logic        wb_wb_en,
    input  logic [4:0]  mem_dest,
    input  logic [4:0]  wb_dest,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if2id_en,
    output logic        id2ex_en,
    output logic        ex2mem_en,
    output logic        mem2wb_en,
    output logic        if2id_flush,
    output logic        id2ex_bubble,
    output logic        mem2wb_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt,
    output logic        mem_err
);

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mem_err_q, mem_err_d;
    ctrl_t       ctrl;
    logic        load_use;

    assign load_use = ex_mem_read && (ex_dest != 5'd0) &&
                      ((id_src1 == ex_dest) || (id_two_src && (id_src2 == ex_dest)));

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        ctrl      = CTRL_RUN;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    ctrl    = CTRL_FREEZE;
                    state_d = ST_MEM_WAIT;
                    wait_d  = 8'd0;
                end else if (branch_taken) begin
                    ctrl = CTRL_BRANCH;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end
            ST_MEM_WAIT: begin
                // Once the access is outstanding we wait on mem_ready alone.
                if (!mem_ready) begin
                    ctrl   = CTRL_FREEZE;
                    wait_d = wait_q + 8'd1;
                    if (wait_q == TIMEOUT_W) begin
                        state_d   = ST_ERR;
                        mem_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                ctrl = CTRL_OFF;
            end
            default: begin
                ctrl    = CTRL_OFF;
                state_d = ST_RUN;
            end
        endcase
        if (!rst) begin
            ctrl = CTRL_OFF;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_en && (state_q != ST_ERR) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_q      <= 8'd0;
            stall_cnt_q <= 16'd0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    fwd_unit u_fwd_unit (
        .ex_src1   (ex_src1),
        .ex_src2   (ex_src2),
        .mem_wb_en (mem_wb_en),
        .mem_dest  (mem_dest),
        .wb_wb_en  (wb_wb_en),
        .wb_dest   (wb_dest),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b)
    );

    assign pc_en         = ctrl.pc_en;
    assign if2id_en      = ctrl.if2id_en;
    assign id2ex_en      = ctrl.id2ex_en;
    assign ex2mem_en     = ctrl.ex2mem_en;
    assign mem2wb_en     = ctrl.mem2wb_en;
    assign if2id_flush   = ctrl.if2id_flush;
    assign id2ex_bubble  = ctrl.id2ex_bubble;
    assign mem2wb_bubble = ctrl.mem2wb_bubble;
    assign stall_cnt     = stall_cnt_q;
    assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed cycles push expected outputs into a
// scoreboard queue; a negedge monitor pops and compares each transaction.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_src1, id_src2, ex_src1, ex_src2, ex_dest, mem_dest, wb_dest;
    logic        id_two_src, ex_mem_read, branch_taken, mem_wb_en, wb_wb_en;
    logic        mem_req, mem_ready;
    logic        pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en;
    logic        if2id_flush, id2ex_bubble, mem2wb_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic        mem_err;

    // Control vector order: pc,if2id,id2ex,ex2mem,mem2wb,flush,id2ex_bub,mem2wb_bub
    localparam logic [7:0] C_OFF  = 8'b00000_000;
    localparam logic [7:0] C_NORM = 8'b11111_000;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_BR   = 8'b11111_110;
    localparam logic [7:0] C_FRZ  = 8'b00001_001;

    typedef struct {
        string       tag;
        logic [7:0]  ctrl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] sc;
        logic        me;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_ctrl #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_src1       (id_src1),
        .id_src2       (id_src2),
        .id_two_src    (id_two_src),
        .ex_src1       (ex_src1),
        .ex_src2       (ex_src2),
        .ex_mem_read   (ex_mem_read),
        .ex_dest       (ex_dest),
        .branch_taken  (branch_taken),
        .mem_wb_en     (mem_wb_en),
        .wb_wb_en      (wb_wb_en),
        .mem_dest      (mem_dest),
        .wb_dest       (wb_dest),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_en         (pc_en),
        .if2id_en      (if2id_en),
        .id2ex_en      (id2ex_en),
        .ex2mem_en     (ex2mem_en),
        .mem2wb_en     (mem2wb_en),
        .if2id_flush   (if2id_flush),
        .id2ex_bubble  (id2ex_bubble),
        .mem2wb_bubble (mem2wb_bubble),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall_cnt     (stall_cnt),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [7:0] obs_ctrl;
            e = sb.pop_front();
            obs_ctrl = {pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en,
                        if2id_flush, id2ex_bubble, mem2wb_bubble};
            $display("[%0t] %s ctrl=%b fwd=%b/%b stall_cnt=%0d mem_err=%b",
                     $time, e.tag, obs_ctrl, fwd_a, fwd_b, stall_cnt, mem_err);
            check({e.tag, ".ctrl"},      32'(obs_ctrl),  32'(e.ctrl));
            check({e.tag, ".fwd_a"},     32'(fwd_a),     32'(e.fa));
            check({e.tag, ".fwd_b"},     32'(fwd_b),     32'(e.fb));
            check({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
            check({e.tag, ".mem_err"},   32'(mem_err),   32'(e.me));
        end
    end

    task automatic idle();
        id_src1 = 5'd0; id_src2 = 5'd0; id_two_src = 1'b0;
        ex_src1 = 5'd0; ex_src2 = 5'd0; ex_mem_read = 1'b0; ex_dest = 5'd0;
        branch_taken = 1'b0;
        mem_wb_en = 1'b0; wb_wb_en = 1'b0; mem_dest = 5'd0; wb_dest = 5'd0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Inputs are already set; queue the expectation and advance one cycle.
    task automatic cyc(input string tag, input logic [7:0] ctrl, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [15:0] sc, input logic me);
        exp_t e;
        e.tag = tag; e.ctrl = ctrl; e.fa = fa; e.fb = fb; e.sc = sc; e.me = me;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        cyc("rst0", C_OFF, 2'b00, 2'b00, 16'd0, 1'b0);
        cyc("rst1", C_OFF, 2'b00, 2'b00, 16'd0, 1'b0);
        rst = 1'b1;
        cyc("run", C_NORM, 2'b00, 2'b00, 16'd0, 1'b0);

        // Load-use on src1 (r5): one stall cycle
        ex_mem_read = 1'b1; ex_dest = 5'd5; id_src1 = 5'd5;
        cyc("lu_src1", C_LU, 2'b00, 2'b00, 16'd0, 1'b0);
        idle();
        cyc("lu_after", C_NORM, 2'b00, 2'b00, 16'd1, 1'b0);
        // Load-use on src2 only counts when id_two_src
        ex_mem_read = 1'b1; ex_dest = 5'd6; id_src1 = 5'd1; id_src2 = 5'd6; id_two_src = 1'b1;
        cyc("lu_src2", C_LU, 2'b00, 2'b00, 16'd1, 1'b0);
        id_two_src = 1'b0;
        cyc("lu_src2_one", C_NORM, 2'b00, 2'b00, 16'd2, 1'b0);
        idle();
        ex_mem_read = 1'b1; ex_dest = 5'd0; id_src1 = 5'd0;
        cyc("lu_r0", C_NORM, 2'b00, 2'b00, 16'd2, 1'b0);

        // Branch overrides concurrent load-use on r3
        idle();
        ex_mem_read = 1'b1; ex_dest = 5'd3; id_src1 = 5'd3; branch_taken = 1'b1;
        cyc("br_lu", C_BR, 2'b00, 2'b00, 16'd2, 1'b0);
        idle();
        cyc("br_after", C_NORM, 2'b00, 2'b00, 16'd2, 1'b0);

        // Memory stall: ready low for 3 cycles then high
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc("mst_run", C_FRZ, 2'b00, 2'b00, 16'd2, 1'b0);
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd3; id_src1 = 5'd3;
        cyc("mst_w1", C_FRZ, 2'b00, 2'b00, 16'd3, 1'b0);
        idle(); mem_req = 1'b1;
        cyc("mst_w2", C_FRZ, 2'b00, 2'b00, 16'd4, 1'b0);
        mem_ready = 1'b1;
        cyc("mst_rel", C_NORM, 2'b00, 2'b00, 16'd5, 1'b0);
        idle();
        cyc("mst_after", C_NORM, 2'b00, 2'b00, 16'd5, 1'b0);

        // Forwarding
        mem_wb_en = 1'b1; wb_wb_en = 1'b1; mem_dest = 5'd7; wb_dest = 5'd7;
        ex_src1 = 5'd7; ex_src2 = 5'd7;
        cyc("fwd_mem_pri", C_NORM, 2'b01, 2'b01, 16'd5, 1'b0);
        mem_wb_en = 1'b0;
        cyc("fwd_wb", C_NORM, 2'b10, 2'b10, 16'd5, 1'b0);
        mem_wb_en = 1'b1; mem_dest = 5'd0; wb_dest = 5'd0; ex_src1 = 5'd0; ex_src2 = 5'd0;
        cyc("fwd_r0", C_NORM, 2'b00, 2'b00, 16'd5, 1'b0);
        mem_dest = 5'd9; wb_dest = 5'd4; ex_src1 = 5'd4; ex_src2 = 5'd9;
        cyc("fwd_mix", C_NORM, 2'b10, 2'b01, 16'd5, 1'b0);
        idle();

        // Timeout with TIMEOUT=4
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc("to_run", C_FRZ, 2'b00, 2'b00, 16'd5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("to_wait%0d", i), C_FRZ, 2'b00, 2'b00, 16'(6 + i), 1'b0);
        end
        cyc("to_err", C_OFF, 2'b00, 2'b00, 16'd11, 1'b1);
        mem_ready = 1'b1; mem_wb_en = 1'b1; mem_dest = 5'd7; ex_src1 = 5'd7;
        cyc("to_err_hold", C_OFF, 2'b01, 2'b00, 16'd11, 1'b1);
        idle();
        rst = 1'b0;
        cyc("to_rst", C_OFF, 2'b00, 2'b00, 16'd11, 1'b1);
        rst = 1'b1;
        cyc("to_rst_run", C_NORM, 2'b00, 2'b00, 16'd0, 1'b0);

        // Reset in the middle of MEM_WAIT
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc("mwr_run", C_FRZ, 2'b00, 2'b00, 16'd0, 1'b0);
        cyc("mwr_wait", C_FRZ, 2'b00, 2'b00, 16'd1, 1'b0);
        rst = 1'b0;
        cyc("mwr_rst", C_OFF, 2'b00, 2'b00, 16'd2, 1'b0);
        rst = 1'b1; mem_req = 1'b0;
        // In MEM_WAIT this would still freeze (ready low); in RUN it runs.
        cyc("mwr_post", C_NORM, 2'b00, 2'b00, 16'd0, 1'b0);
        cyc("mwr_post2", C_NORM, 2'b00, 2'b00, 16'd0, 1'b0);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
